// File: rtl/nfu_ctrl_pkg.sv
// Shared types for the NFU sequencing controller: FSM states and the in-flight block tag.
package nfu_ctrl_pkg;

    localparam int TAG_O_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        COEF,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               first;
        logic               last;
        logic [TAG_O_W-1:0] o;
    } tag_t;

endpackage

// File: rtl/nfu_tag_pipe.sv
// Shift register of block tags; taps[k] is the tag issued k cycles ago (taps[0] = current issue).
module nfu_tag_pipe
    import nfu_ctrl_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  tag_t                   tag_in,
    output tag_t [DEPTH-1:0]       taps
);

    tag_t [DEPTH-1:1] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[1] <= tag_in;
            for (int k = 2; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    always_comb begin
        taps    = '0;
        taps[0] = tag_in;
        for (int k = 1; k < DEPTH; k++) begin
            taps[k] = pipe_q[k];
        end
    end

endmodule

// File: rtl/nfu_ctrl.sv
// NFU pipeline sequencer: coefficient load, block issue, NBout read/load/write timing.
// Optional performance counters are built when NFU_CTRL_PERF_EN is defined.
module nfu_ctrl
    import nfu_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 10,
    parameter int NFU2_LAT    = 4,
    parameter int NFU3_LAT    = 2,
    parameter int SIG_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_load_coef,
    input  logic [CNT_W-1:0]  i_num_in_blk,
    input  logic [CNT_W-1:0]  i_num_out_blk,
    input  logic              i_accum_nbout,
    input  logic              i_partial_out,
    input  logic              i_stall,
    input  logic              i_coef_valid,
    output logic              o_coef_ready,
    output logic              o_load_sigmoid_coef,
    output logic              o_nbin_rd_en,
    output logic [ADDR_W-1:0] o_nbin_addr,
    output logic              o_sb_rd_en,
    output logic [ADDR_W-1:0] o_sb_addr,
    output logic              o_nbout_rd_en,
    output logic              o_nbout_zero,
    output logic              o_load_nbout,
    output logic [ADDR_W-1:0] o_nbout_addr,
    output logic              o_nbout_wr_en,
    output logic              o_nbout_nfu2_nfu3,
    output logic              o_busy,
    output logic              o_done
`ifdef NFU_CTRL_PERF_EN
    ,
    output logic [31:0]       o_perf_busy_cycles,
    output logic [31:0]       o_perf_stall_cycles
`endif
);

    localparam int DEPTH  = NFU2_LAT + NFU3_LAT;
    localparam int COEF_W = $clog2(SIG_ENTRIES + 1);
    // Next block's NFU-2/NFU-3 load must land after the previous block's NFU-3 write.
    localparam logic [7:0] GAP = 8'(NFU3_LAT + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    num_in_q, num_out_q, j_q, o_q, pend_q;
    logic                accum_q, partial_q;
    logic [ADDR_W-1:0]   sb_q;
    logic [7:0]          gap_q;
    logic [COEF_W-1:0]   coef_cnt_q;
    logic [TAG_O_W-1:0]  pend_o_q;
    tag_t                iss_tag_q;
    tag_t [DEPTH-1:0]    taps;
    tag_t                rd_tap, ld_tap, wr_tap;
    logic                rd_req, wr_req, zero_req, pipe_empty, coef_beat;

    nfu_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (iss_tag_q),
        .taps   (taps)
    );

    assign rd_tap    = taps[NFU2_LAT-3];
    assign ld_tap    = taps[NFU2_LAT-2];
    assign wr_tap    = partial_q ? taps[NFU2_LAT-1] : taps[DEPTH-1];
    assign rd_req    = accum_q & rd_tap.valid & rd_tap.first;
    assign zero_req  = !accum_q & ld_tap.valid & ld_tap.first;
    assign wr_req    = wr_tap.valid & wr_tap.last;
    assign coef_beat = i_coef_valid & o_coef_ready;
    assign o_load_sigmoid_coef = coef_beat;

    always_comb begin
        pipe_empty = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (taps[k].valid && (k < (partial_q ? NFU2_LAT : DEPTH))) pipe_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            num_in_q          <= '0;
            num_out_q         <= '0;
            j_q               <= '0;
            o_q               <= '0;
            pend_q            <= '0;
            pend_o_q          <= '0;
            accum_q           <= 1'b0;
            partial_q         <= 1'b0;
            sb_q              <= '0;
            gap_q             <= '0;
            coef_cnt_q        <= '0;
            iss_tag_q         <= '0;
            o_coef_ready      <= 1'b0;
            o_nbin_rd_en      <= 1'b0;
            o_nbin_addr       <= '0;
            o_sb_rd_en        <= 1'b0;
            o_sb_addr         <= '0;
            o_nbout_rd_en     <= 1'b0;
            o_nbout_zero      <= 1'b0;
            o_load_nbout      <= 1'b0;
            o_nbout_addr      <= '0;
            o_nbout_wr_en     <= 1'b0;
            o_nbout_nfu2_nfu3 <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            o_done            <= 1'b0;
            o_nbin_rd_en      <= 1'b0;
            o_sb_rd_en        <= 1'b0;
            iss_tag_q         <= '0;
            o_nbout_rd_en     <= 1'b0;
            o_nbout_wr_en     <= wr_req;
            o_nbout_nfu2_nfu3 <= wr_req & partial_q;
            o_load_nbout      <= accum_q ? o_nbout_rd_en : zero_req;
            o_nbout_zero      <= zero_req;

            // Writes own the NBout address; colliding reads queue up in o order.
            if (wr_req) begin
                o_nbout_addr <= ADDR_W'(wr_tap.o);
                if (rd_req) begin
                    if (pend_q == '0) pend_o_q <= rd_tap.o;
                    pend_q <= pend_q + ONE;
                end
            end else if (pend_q != '0) begin
                o_nbout_rd_en <= 1'b1;
                o_nbout_addr  <= ADDR_W'(pend_o_q);
                pend_o_q      <= pend_o_q + 1'b1;
                if (!rd_req) pend_q <= pend_q - ONE;
            end else if (rd_req) begin
                o_nbout_rd_en <= 1'b1;
                o_nbout_addr  <= ADDR_W'(rd_tap.o);
            end

            case (state)
                IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start && !o_busy) begin
                        num_in_q   <= i_num_in_blk;
                        num_out_q  <= i_num_out_blk;
                        accum_q    <= i_accum_nbout;
                        partial_q  <= i_partial_out;
                        j_q        <= '0;
                        o_q        <= '0;
                        sb_q       <= '0;
                        gap_q      <= '0;
                        coef_cnt_q <= '0;
                        o_busy     <= 1'b1;
                        if (i_load_coef) begin
                            state        <= COEF;
                            o_coef_ready <= 1'b1;
                        end else if (i_num_in_blk == '0 || i_num_out_blk == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                COEF: begin
                    if (coef_beat) begin
                        coef_cnt_q <= coef_cnt_q + 1'b1;
                        if (coef_cnt_q == COEF_W'(SIG_ENTRIES - 1)) begin
                            o_coef_ready <= 1'b0;
                            if (num_in_q == '0 || num_out_q == '0) begin
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 8'd1;
                    end else if (!i_stall) begin
                        o_nbin_rd_en    <= 1'b1;
                        o_sb_rd_en      <= 1'b1;
                        o_nbin_addr     <= ADDR_W'(j_q);
                        o_sb_addr       <= sb_q;
                        sb_q            <= sb_q + 1'b1;
                        iss_tag_q.valid <= 1'b1;
                        iss_tag_q.first <= (j_q == '0);
                        iss_tag_q.last  <= (j_q == num_in_q - ONE);
                        iss_tag_q.o     <= TAG_O_W'(o_q);
                        if (j_q == num_in_q - ONE) begin
                            j_q <= '0;
                            if (o_q == num_out_q - ONE) begin
                                state <= DRAIN;
                            end else begin
                                o_q <= o_q + ONE;
                                if (!partial_q) gap_q <= GAP;
                            end
                        end else begin
                            j_q <= j_q + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty && pend_q == '0 && !o_nbout_rd_en) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NFU_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_busy_cycles  <= '0;
            o_perf_stall_cycles <= '0;
        end else if (state == IDLE && i_start && !o_busy) begin
            o_perf_busy_cycles  <= '0;
            o_perf_stall_cycles <= '0;
        end else begin
            if (o_busy && !(&o_perf_busy_cycles))
                o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
            if (state == ISSUE && i_stall && !(&o_perf_stall_cycles))
                o_perf_stall_cycles <= o_perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
